// File: rtl/wb_rf_writer_pkg.sv
// Shared definitions for the writeback stage: FSM states, load funct3
// encodings and the hard-wired zero register index.
package wb_rf_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_RETIRE    = 3'd4
    } wb_state_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    // x0 never takes a write; compared after casting to the index width.
    localparam int REG_ZERO = 0;

    localparam int PC_WIDTH = 32;

endpackage

// File: rtl/wb_rf_writer_load_extender.sv
// Combinational load formatter: picks the byte/halfword addressed by the
// low address bits out of the aligned load word and sign/zero-extends it.
// An unsupported funct3 yields zero and raises the error flag.
module load_extender
    import wb_rf_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic                  o_err
);

    logic [DATA_WIDTH-1:0] w_byte_shift;
    logic [DATA_WIDTH-1:0] w_half_shift;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // Lane selection and extension; halfwords ignore addr_lo[0] (aligned by the LSU)
    always_comb begin
        w_byte_shift = i_rdata >> {i_addr_lo, 3'b000};
        w_half_shift = i_rdata >> {i_addr_lo[1], 4'b0000};
        w_byte       = w_byte_shift[7:0];
        w_half       = w_half_shift[15:0];
        o_value      = '0;
        o_err        = 1'b0;
        case (i_funct3)
            LOAD_LB:  o_value = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            LOAD_LH:  o_value = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            LOAD_LW:  o_value = i_rdata;
            LOAD_LBU: o_value = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            LOAD_LHU: o_value = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: begin
                o_value = '0;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_rf_writer.sv
// Writeback stage: accepts one completed instruction at a time from the EXU,
// waits for load data when needed, drives the register-file write strobe,
// waits for the write-done handshake and then emits a one-cycle commit.
module wb_rf_writer
    import wb_rf_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [PC_WIDTH-1:0]   exu_pc,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic                  exu_is_load,
    input  logic [2:0]            exu_funct3,
    input  logic [1:0]            exu_addr_lo,
    input  logic [DATA_WIDTH-1:0] exu_result,
    input  logic                  exu_ecall,
    input  logic                  lsu_rvalid,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic                  rf_wen,
    output logic                  rf_ivalid,
    input  logic                  rf_evalid,
    output logic                  commit_valid,
    output logic [PC_WIDTH-1:0]   commit_pc,
    output logic                  commit_ecall,
    output logic                  wb_err
);

    localparam logic [ADDR_WIDTH-1:0] RD_ZERO = ADDR_WIDTH'(REG_ZERO);

    wb_state_e             r_state;
    wb_state_e             w_state_nxt;

    logic [PC_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_wen;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_ecall;

    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic                  r_rf_wen;
    logic                  r_rf_ivalid;
    logic                  r_commit_valid;
    logic [PC_WIDTH-1:0]   r_commit_pc;
    logic                  r_commit_ecall;
    logic                  r_wb_err;

    logic                  w_accept;
    logic                  w_load_done;
    logic [DATA_WIDTH-1:0] w_ext_value;
    logic                  w_ext_err;
    logic                  w_wr_wen;
    logic [ADDR_WIDTH-1:0] w_wr_rd;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_do_strobe;
    logic                  w_do_commit;

    load_extender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extender (
        .i_rdata   (lsu_rdata),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .o_value   (w_ext_value),
        .o_err     (w_ext_err)
    );

    // Ready only in IDLE and never while reset is asserted
    assign exu_ready = rst_n & (r_state == ST_IDLE);

    // Next-state decode plus the accept / load-completion events
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exu_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = exu_is_load ? ST_WAIT_LOAD : ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (lsu_rvalid) begin
                    w_load_done = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_WAIT_LOAD;
                end
            end
            ST_WRITE: begin
                if (r_wen && (r_rd != RD_ZERO)) begin
                    w_state_nxt = ST_WAIT_ACK;
                end else begin
                    w_state_nxt = ST_RETIRE;
                end
            end
            ST_WAIT_ACK: begin
                if (rf_evalid) begin
                    w_state_nxt = ST_RETIRE;
                end else begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_RETIRE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Write-side operands for the cycle about to enter WRITE: straight from
    // the EXU on a non-load accept, from the holding regs + extender on a load
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_wr_wen  = exu_wen;
            w_wr_rd   = exu_rd;
            w_wr_data = exu_result;
        end else begin
            w_wr_wen  = r_wen;
            w_wr_rd   = r_rd;
            w_wr_data = w_ext_value;
        end
        w_do_strobe = (w_state_nxt == ST_WRITE) && w_wr_wen && (w_wr_rd != RD_ZERO);
        w_do_commit = (w_state_nxt == ST_RETIRE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers for the single in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_ecall   <= 1'b0;
        end else if (w_accept) begin
            r_pc      <= exu_pc;
            r_rd      <= exu_rd;
            r_wen     <= exu_wen;
            r_funct3  <= exu_funct3;
            r_addr_lo <= exu_addr_lo;
            r_ecall   <= exu_ecall;
        end
    end

    // Registered RF write port and commit port, aligned with WRITE / RETIRE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_wen       <= 1'b0;
            r_rf_ivalid    <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_commit_ecall <= 1'b0;
        end else begin
            r_rf_wen       <= w_do_strobe;
            r_rf_ivalid    <= w_do_strobe;
            r_rf_waddr     <= w_do_strobe ? w_wr_rd : '0;
            r_rf_wdata     <= w_do_strobe ? w_wr_data : '0;
            r_commit_valid <= w_do_commit;
            r_commit_pc    <= w_do_commit ? r_pc : '0;
            r_commit_ecall <= w_do_commit & r_ecall;
        end
    end

    // Sticky error for an unsupported load funct3, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_err <= 1'b0;
        end else if (w_load_done && w_ext_err) begin
            r_wb_err <= 1'b1;
        end
    end

    assign rf_wdata     = r_rf_wdata;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wen       = r_rf_wen;
    assign rf_ivalid    = r_rf_ivalid;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
    assign commit_ecall = r_commit_ecall;
    assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_wb_rf_writer.sv
// Self-checking bench for wb_rf_writer: a behavioural register file answers
// every strobe one cycle later, and each scenario task compares the observed
// strobe/commit timing and data against values derived from the ISA rules.
module tb_wb_rf_writer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exu_valid;
    logic          exu_ready;
    logic [31:0]   exu_pc;
    logic [AW-1:0] exu_rd;
    logic          exu_wen;
    logic          exu_is_load;
    logic [2:0]    exu_funct3;
    logic [1:0]    exu_addr_lo;
    logic [DW-1:0] exu_result;
    logic          exu_ecall;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_waddr;
    logic          rf_wen;
    logic          rf_ivalid;
    logic          rf_evalid = 1'b0;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          commit_ecall;
    logic          wb_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] rf_mem [0:31] = '{default: 32'h0};

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        is_load;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] result;
        logic        ecall;
        logic [31:0] rdata;
        int          ldelay;
        bit          stray;
    } instr_t;

    typedef struct {
        int          strobe_cnt;
        int          strobe_off;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        bit          ctl_split;
        int          commit_cnt;
        int          commit_off;
        logic [31:0] cpc;
        logic        cecall;
        bit          ready_start;
        bit          ready_low;
        bit          ready_back;
    } obs_t;

    always #5 clk = ~clk;

    wb_rf_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_pc(exu_pc),
        .exu_rd(exu_rd), .exu_wen(exu_wen), .exu_is_load(exu_is_load),
        .exu_funct3(exu_funct3), .exu_addr_lo(exu_addr_lo),
        .exu_result(exu_result), .exu_ecall(exu_ecall),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .rf_wdata(rf_wdata), .rf_waddr(rf_waddr), .rf_wen(rf_wen),
        .rf_ivalid(rf_ivalid), .rf_evalid(rf_evalid),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_ecall(commit_ecall), .wb_err(wb_err)
    );

    // cycle counter and behavioural register file (write-done one cycle after strobe)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rf_evalid <= rf_ivalid;
        if (rf_ivalid && rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    end

    // reference load formatting from the ISA definition
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * lo)) & 32'h0000_00FF;
        h = (d >> (16 * (lo / 2))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  ref_load = (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  ref_load = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'b010:  ref_load = d;
            3'b100:  ref_load = b;
            3'b101:  ref_load = h;
            default: ref_load = 32'h0;
        endcase
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                                  input logic is_load, input logic [2:0] f3, input logic [1:0] lo,
                                  input logic [31:0] result, input logic ecall,
                                  input logic [31:0] rdata, input int ldelay);
        instr_t t;
        t.pc = pc; t.rd = rd; t.wen = wen; t.is_load = is_load; t.f3 = f3; t.lo = lo;
        t.result = result; t.ecall = ecall; t.rdata = rdata; t.ldelay = ldelay; t.stray = 1'b0;
        return t;
    endfunction

    // drive one instruction (called just after a negedge) and record what the DUT did
    task automatic run_instr(input instr_t ins, input bit hold, output obs_t o);
        int acc_cyc;
        int rsp_cyc;
        int strobe_cyc;
        int commit_cyc;
        int base;
        bit done;
        o = '{default: 0};
        o.ready_low   = 1'b1;
        o.ready_start = exu_ready;
        exu_valid = 1'b1; exu_pc = ins.pc; exu_rd = ins.rd; exu_wen = ins.wen;
        exu_is_load = ins.is_load; exu_funct3 = ins.f3; exu_addr_lo = ins.lo;
        exu_result = ins.result; exu_ecall = ins.ecall;
        acc_cyc = cyc; rsp_cyc = cyc; strobe_cyc = -1000; commit_cyc = -1000; done = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            lsu_rvalid = 1'b0;
            if (!hold) exu_valid = 1'b0;
            if (rf_ivalid || rf_wen) begin
                o.strobe_cnt++;
                strobe_cyc = cyc;
                o.wdata = rf_wdata;
                o.waddr = rf_waddr;
                if (rf_ivalid !== rf_wen) o.ctl_split = 1'b1;
            end
            if (commit_valid) begin
                o.commit_cnt++;
                commit_cyc = cyc;
                o.cpc = commit_pc;
                o.cecall = commit_ecall;
                done = 1'b1;
            end
            if (exu_ready !== 1'b0) o.ready_low = 1'b0;
            if (done) break;
            if (ins.is_load && k == ins.ldelay) begin
                lsu_rvalid = 1'b1; lsu_rdata = ins.rdata; rsp_cyc = cyc;
            end else if (!ins.is_load && ins.stray && k == 1) begin
                lsu_rvalid = 1'b1; lsu_rdata = $urandom;
            end
        end
        @(negedge clk);
        lsu_rvalid = 1'b0;
        o.ready_back = exu_ready;
        if (commit_valid) o.commit_cnt++;
        base = ins.is_load ? rsp_cyc : acc_cyc;
        o.strobe_off = strobe_cyc - base;
        o.commit_off = commit_cyc - base;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; exu_valid = 1'b0; exu_pc = '0; exu_rd = '0; exu_wen = 1'b0;
        exu_is_load = 1'b0; exu_funct3 = 3'b000; exu_addr_lo = 2'b00; exu_result = '0;
        exu_ecall = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rf_wdata, rf_waddr, rf_wen, rf_ivalid, commit_valid, commit_pc, commit_ecall, wb_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wen=%0b iv=%0b cv=%0b err=%0b wdata=%h, expected all 0",
                     rf_wen, rf_ivalid, commit_valid, wb_err, rf_wdata);
        end
        n_cmp++;
        if (exu_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %0b expected 0", exu_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (exu_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after: got %0b expected 1", exu_ready);
        end
    endtask

    task automatic test_alu();
        obs_t o;
        run_instr(mk(32'h0000_0100, 5'd5, 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_1234, 1'b0, 32'h0, 0), 1'b0, o);
        n_cmp++; if (o.strobe_cnt !== 1 || o.strobe_off !== 1 || o.ctl_split) begin
            n_fail++; $display("FAIL alu_strobe: got cnt=%0d off=%0d split=%0b expected 1/1/0", o.strobe_cnt, o.strobe_off, o.ctl_split); end
        n_cmp++; if (o.waddr !== 5'd5 || o.wdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL alu_wdata: got a=%0d d=%h expected 5/00001234", o.waddr, o.wdata); end
        n_cmp++; if (o.commit_cnt !== 1 || o.commit_off !== 3) begin
            n_fail++; $display("FAIL alu_commit: got cnt=%0d off=%0d expected 1/3", o.commit_cnt, o.commit_off); end
        n_cmp++; if (o.cpc !== 32'h0000_0100 || o.cecall !== 1'b0) begin
            n_fail++; $display("FAIL alu_pc: got pc=%h ecall=%0b expected 00000100/0", o.cpc, o.cecall); end
        n_cmp++; if (!o.ready_low || !o.ready_back) begin
            n_fail++; $display("FAIL alu_ready: got low=%0b back=%0b expected 1/1", o.ready_low, o.ready_back); end
        n_cmp++; if (rf_mem[5] !== 32'h0000_1234) begin
            n_fail++; $display("FAIL alu_rf: got x5=%h expected 00001234", rf_mem[5]); end
    endtask

    task automatic test_rd_zero();
        obs_t o;
        run_instr(mk(32'h0000_0200, 5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 32'hDEAD_BEEF, 1'b0, 32'h0, 0), 1'b0, o);
        n_cmp++; if (o.strobe_cnt !== 0) begin
            n_fail++; $display("FAIL rd0_no_strobe: got %0d strobes expected 0", o.strobe_cnt); end
        n_cmp++; if (o.commit_cnt !== 1 || o.commit_off !== 2 || o.cpc !== 32'h0000_0200) begin
            n_fail++; $display("FAIL rd0_commit: got cnt=%0d off=%0d pc=%h expected 1/2/00000200", o.commit_cnt, o.commit_off, o.cpc); end
        n_cmp++; if (rf_mem[0] !== 32'h0) begin
            n_fail++; $display("FAIL rd0_x0: got x0=%h expected 0", rf_mem[0]); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  los  [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F81, 32'h80FF_7F81};
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            run_instr(mk(32'h0000_0300 + 32'(4 * i), 5'(6 + i), 1'b1, 1'b1, f3s[i], los[i], 32'h5555_5555,
                         1'b0, 32'h80FF_7F81, 1 + (i % 3)), 1'b0, o);
            n_cmp++; if (o.wdata !== exps[i] || o.waddr !== 5'(6 + i) || o.strobe_cnt !== 1) begin
                n_fail++; $display("FAIL load%0d_data: got d=%h a=%0d cnt=%0d expected %h/%0d/1", i, o.wdata, o.waddr, o.strobe_cnt, exps[i], 6 + i); end
            n_cmp++; if (o.strobe_off !== 1 || o.commit_off !== 3 || o.commit_cnt !== 1) begin
                n_fail++; $display("FAIL load%0d_timing: got strobe+%0d commit+%0d cnt=%0d expected +1/+3/1", i, o.strobe_off, o.commit_off, o.commit_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            run_instr(mk(32'h0000_1000 + 32'(16 * i), 5'(10 + i), 1'b1, 1'b0, 3'b000, 2'b00,
                         32'hA000_0000 + 32'(i), 1'b0, 32'h0, 0), 1'b1, o);
            n_cmp++; if (o.commit_cnt !== 1 || o.cpc !== 32'h0000_1000 + 32'(16 * i)) begin
                n_fail++; $display("FAIL b2b%0d_commit: got cnt=%0d pc=%h expected 1/%h", i, o.commit_cnt, o.cpc, 32'h0000_1000 + 32'(16 * i)); end
            n_cmp++; if (!o.ready_low || !o.ready_back || o.commit_off !== 3) begin
                n_fail++; $display("FAIL b2b%0d_ready: got low=%0b back=%0b off=%0d expected 1/1/3", i, o.ready_low, o.ready_back, o.commit_off); end
        end
        exu_valid = 1'b0;
    endtask

    task automatic test_ecall();
        obs_t o;
        run_instr(mk(32'h0000_2000, 5'd3, 1'b0, 1'b0, 3'b000, 2'b00, 32'h1111_2222, 1'b1, 32'h0, 0), 1'b0, o);
        n_cmp++; if (o.strobe_cnt !== 0) begin
            n_fail++; $display("FAIL ecall_no_strobe: got %0d strobes expected 0", o.strobe_cnt); end
        n_cmp++; if (o.commit_cnt !== 1 || o.commit_off !== 2 || o.cecall !== 1'b1 || o.cpc !== 32'h0000_2000) begin
            n_fail++; $display("FAIL ecall_commit: got cnt=%0d off=%0d ecall=%0b pc=%h expected 1/2/1/00002000", o.commit_cnt, o.commit_off, o.cecall, o.cpc); end
    endtask

    task automatic test_random();
        logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        instr_t t;
        obs_t o;
        bit exp_strobe;
        logic [31:0] exp_data;
        for (int i = 0; i < 40; i++) begin
            t = mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   legal[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 7) == 0),
                   $urandom, $urandom_range(1, 4));
            t.stray = 1'($urandom_range(0, 1));
            run_instr(t, 1'b0, o);
            exp_strobe = t.wen && (t.rd != 5'd0);
            exp_data   = t.is_load ? ref_load(t.rdata, t.f3, t.lo) : t.result;
            n_cmp++;
            if (o.strobe_cnt !== (exp_strobe ? 1 : 0) || (exp_strobe && (o.strobe_off !== 1 || o.waddr !== t.rd || o.wdata !== exp_data))) begin
                n_fail++; $display("FAIL rand%0d_write: got cnt=%0d off=%0d a=%0d d=%h expected cnt=%0d a=%0d d=%h", i,
                                   o.strobe_cnt, o.strobe_off, o.waddr, o.wdata, exp_strobe ? 1 : 0, t.rd, exp_data); end
            n_cmp++;
            if (o.commit_cnt !== 1 || o.commit_off !== (exp_strobe ? 3 : 2) || o.cpc !== t.pc || o.cecall !== t.ecall) begin
                n_fail++; $display("FAIL rand%0d_commit: got cnt=%0d off=%0d pc=%h ec=%0b expected 1/%0d/%h/%0b", i,
                                   o.commit_cnt, o.commit_off, o.cpc, o.cecall, exp_strobe ? 3 : 2, t.pc, t.ecall); end
            n_cmp++;
            if (!o.ready_start || !o.ready_low || !o.ready_back || o.ctl_split) begin
                n_fail++; $display("FAIL rand%0d_ready: got start=%0b low=%0b back=%0b split=%0b expected 1/1/1/0", i,
                                   o.ready_start, o.ready_low, o.ready_back, o.ctl_split); end
        end
        n_cmp++; if (wb_err !== 1'b0) begin
            n_fail++; $display("FAIL rand_err_clear: got wb_err=%0b expected 0", wb_err); end
    endtask

    task automatic test_bad_funct3();
        obs_t o;
        run_instr(mk(32'h0000_3000, 5'd7, 1'b1, 1'b1, 3'b011, 2'b00, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 2), 1'b0, o);
        n_cmp++; if (o.strobe_cnt !== 1 || o.wdata !== 32'h0 || o.waddr !== 5'd7) begin
            n_fail++; $display("FAIL bad_f3_data: got cnt=%0d d=%h a=%0d expected 1/00000000/7", o.strobe_cnt, o.wdata, o.waddr); end
        n_cmp++; if (wb_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_f3_err: got wb_err=%0b expected 1", wb_err); end
        run_instr(mk(32'h0000_3004, 5'd8, 1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0042, 1'b0, 32'h0, 0), 1'b0, o);
        n_cmp++; if (wb_err !== 1'b1 || o.commit_cnt !== 1) begin
            n_fail++; $display("FAIL bad_f3_sticky: got wb_err=%0b commits=%0d expected 1/1", wb_err, o.commit_cnt); end
    endtask

    task automatic test_reset_inflight();
        int seen_strobe;
        int seen_commit;
        exu_valid = 1'b1; exu_pc = 32'h0000_4000; exu_rd = 5'd9; exu_wen = 1'b1;
        exu_is_load = 1'b1; exu_funct3 = 3'b010; exu_addr_lo = 2'b00; exu_ecall = 1'b0;
        @(negedge clk);
        exu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (exu_ready !== 1'b0) begin
            n_fail++; $display("FAIL inflight_busy: got exu_ready=%0b expected 0", exu_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rf_wen, rf_ivalid, commit_valid, wb_err, exu_ready} !== 5'b0 || rf_wdata !== '0 || commit_pc !== '0) begin
            n_fail++; $display("FAIL inflight_reset_outs: got wen=%0b iv=%0b cv=%0b err=%0b rdy=%0b expected all 0",
                               rf_wen, rf_ivalid, commit_valid, wb_err, exu_ready); end
        rst_n = 1'b1;
        lsu_rvalid = 1'b1; lsu_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (exu_ready !== 1'b1) begin
            n_fail++; $display("FAIL inflight_ready_back: got %0b expected 1", exu_ready); end
        seen_strobe = 0; seen_commit = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lsu_rvalid = 1'b0;
            if (rf_wen || rf_ivalid) seen_strobe++;
            if (commit_valid) seen_commit++;
        end
        n_cmp++; if (seen_strobe !== 0 || seen_commit !== 0 || rf_mem[9] === 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL inflight_dropped: got strobes=%0d commits=%0d expected 0/0", seen_strobe, seen_commit); end
    endtask

    // bounded run time regardless of DUT behaviour
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_rd_zero();
        test_loads();
        test_back_to_back();
        test_ecall();
        test_random();
        test_bad_funct3();
        test_reset_inflight();
        test_alu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rf_writer.md
Name: wb_rf_writer

Overview:
- Writeback stage that is the write-side initiator of the integer register file. It takes completed instructions from the EXU and load data from the LSU, sign- or zero-extends loads, and drives the register file write port together with its valid strobe.
- It waits for the register file's write-done valid before it retires the instruction on the commit port, which feeds difftest/trace and ecall halt detection.
- It sits between EXU/LSU and RegFile, and handles one instruction at a time.

Parameters:
- DATA_WIDTH, 32, register/data width
- ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- exu_valid  in  1  EXU offers an instruction
- exu_ready  out  1  writer accepts an instruction
- exu_pc  in  32  instruction PC
- exu_rd  in  ADDR_WIDTH  destination register
- exu_wen  in  1  instruction writes rd
- exu_is_load  in  1  result comes from LSU
- exu_funct3  in  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- exu_addr_lo  in  2  load byte offset
- exu_result  in  DATA_WIDTH  ALU/CSR result
- exu_ecall  in  1  instruction is ecall
- lsu_rvalid  in  1  load response valid, 1-cycle pulse
- lsu_rdata  in  DATA_WIDTH  aligned load word
- rf_wdata  out  DATA_WIDTH  write data
- rf_waddr  out  ADDR_WIDTH  write address
- rf_wen  out  1  write enable
- rf_ivalid  out  1  write strobe valid
- rf_evalid  in  1  RegFile write-done valid, registered one cycle after the strobe
- commit_valid  out  1  1-cycle retire pulse
- commit_pc  out  32  retired PC
- commit_ecall  out  1  retired instruction was ecall
- wb_err  out  1  sticky: unsupported load funct3

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low (`rst_n`).
- Reset: all outputs 0, exu_ready=0 during reset and 1 in the first cycle after it, state IDLE, wb_err cleared. Reset at any point drops an in-flight instruction with no commit. Responses that arrive late after reset are ignored.
- FSM states are IDLE, WAIT_LOAD, WRITE, WAIT_ACK, RETIRE.
- IDLE:
  - exu_ready=1.
  - exu_valid && exu_ready captures pc, rd, wen, is_load, funct3, addr_lo, result, ecall into holding registers.
  - Next state is WAIT_LOAD if is_load, else WRITE.
- WAIT_LOAD:
  - exu_ready=0.
  - On lsu_rvalid, compute the extended value into the holding register and go to WRITE.
  - With no rvalid, wait indefinitely.
- WRITE (exactly 1 cycle):
  - When the held wen=1 and rd!=0: rf_wen=1, rf_ivalid=1, waddr=rd, wdata=held value. Go to WAIT_ACK.
  - Otherwise no strobe is driven (all three rf controls stay 0); go to RETIRE.
- WAIT_ACK:
  - rf_wen and rf_ivalid are 0.
  - On rf_evalid go to RETIRE.
  - rf_evalid seen in any other state is ignored.
- RETIRE:
  - commit_valid=1 with commit_pc and commit_ecall taken from the holding registers. Next state IDLE.
- Latency, acceptance cycle = N:
  - non-load: strobe at N+1, evalid at N+2, commit at N+3.
  - load: response at cycle R, strobe at R+1, commit at R+3.
  - rd=0 or wen=0: commit at N+2 (non-load).
- Throughput: at most one instruction in flight. exu_ready is low from the acceptance cycle until IDLE is re-entered.
- Load extension:
  - byte = lsu_rdata[8*addr_lo +: 8]
  - half = lsu_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored for halfwords (the LSU guarantees alignment)
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
  - Any other funct3 writes 0 and sets wb_err, which stays set until reset.
- lsu_rvalid outside WAIT_LOAD is ignored.
- exu_ecall forces nothing on the write side; it is only reported at commit.
- All outputs are registered except exu_ready, which is combinational from state.

Decomposition:
- Shared package holds: FSM state enum; LOAD_* funct3 constants; REG_ZERO constant.
- One sub-module, load_extender: combinational (rdata, funct3, addr_lo) → (value, err).

Test Plan:
- ALU add: exu_valid with rd=5, result=0x0000_1234, wen=1 → cycle N+1 rf_wen=rf_ivalid=1, waddr=5, wdata=0x1234; RF returns evalid at N+2; commit_valid at N+3 with correct pc.
- rd=0 write with result=0xDEAD_BEEF, wen=1 → no rf strobe; commit_valid at N+2; RF x0 reads 0.
- Loads with lsu_rdata=0x80FF_7F81:
  - LB addr_lo=0 → 0xFFFF_FF81
  - LBU addr_lo=3 → 0x0000_0080
  - LH addr_lo=2 → 0xFFFF_80FF
  - LHU addr_lo=0 → 0x0000_7F81
  - LW → 0x80FF_7F81
  - For each, the write strobe comes one cycle after lsu_rvalid.
- Backpressure: exu_valid held high for 3 back-to-back instructions → exu_ready low during each instruction's processing; each instruction commits exactly once, in order, with its own pc.
- Reset while in WAIT_LOAD, then lsu_rvalid on the next cycle → no rf write, no commit, outputs 0, exu_ready=1 one cycle after rst_n rises. Bad funct3=011 → wdata=0, wb_err=1 until reset.
- ecall with wen=0 → no strobe; commit_valid with commit_ecall=1 at N+2.
